// File: rtl/seq_rca_adder.sv
// Multi-cycle ripple-carry add/sub, DIGIT bits per cycle; optional saturation via SEQ_RCA_ADDER_SAT_EN.
// Latency WIDTH/DIGIT cycles after accept; in_ready only in IDLE, result held in DONE until out_ready.
module seq_rca_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             sign,
   output logic             zero,
   output logic             carry,
   output logic             parity,
   output logic             overflow
);

   localparam int N   = WIDTH / DIGIT;
   localparam int CW  = (N > 1) ? $clog2(N) : 1;
   localparam int MSB = WIDTH - 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic [WIDTH-1:0] r_z;
   logic             r_sign;
   logic             r_zero;
   logic             r_carry_o;
   logic             r_parity;
   logic             r_ovf;

   logic             w_accept;
   logic             w_last;
   int               w_base;
   logic [DIGIT:0]   w_slice;
   logic [WIDTH-1:0] w_sum_nxt;
   logic [WIDTH-1:0] w_zfin;
   logic             w_ovf;

   assign w_last = (r_cnt == CW'(N - 1));

   // One shared ripple slice; the final slice is merged combinationally so
   // z and flags can be registered on the same edge that enters DONE.
   always_comb begin
      w_base    = int'(r_cnt) * DIGIT;
      w_slice   = {1'b0, r_a[w_base +: DIGIT]} + {1'b0, r_b[w_base +: DIGIT]}
                + {{DIGIT{1'b0}}, r_carry};
      w_sum_nxt = r_sum;
      w_sum_nxt[w_base +: DIGIT] = w_slice[DIGIT-1:0];
      w_ovf     = (r_a[MSB] & r_b[MSB] & ~w_sum_nxt[MSB]) |
                  (~r_a[MSB] & ~r_b[MSB] & w_sum_nxt[MSB]);
`ifdef SEQ_RCA_ADDER_SAT_EN
      if (w_ovf)
         w_zfin = r_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else
         w_zfin = w_sum_nxt;
`else
      w_zfin = w_sum_nxt;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_sum     <= '0;
         r_carry   <= 1'b0;
         r_z       <= '0;
         r_sign    <= 1'b0;
         r_zero    <= 1'b0;
         r_carry_o <= 1'b0;
         r_parity  <= 1'b0;
         r_ovf     <= 1'b0;
      end else if (w_accept) begin
         r_a     <= x;
         r_b     <= sub ? ~y : y;
         r_carry <= sub;
         r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
         r_sum   <= w_sum_nxt;
         r_carry <= w_slice[DIGIT];
         r_cnt   <= r_cnt + CW'(1);
         if (w_last) begin
            r_z       <= w_zfin;
            r_sign    <= w_zfin[MSB];
            r_zero    <= (w_zfin == '0);
            r_carry_o <= w_slice[DIGIT];
            r_parity  <= ~^w_zfin;
            r_ovf     <= w_ovf;
         end
      end
   end

   assign z        = r_z;
   assign sign     = r_sign;
   assign zero     = r_zero;
   assign carry    = r_carry_o;
   assign parity   = r_parity;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_seq_rca_adder.sv
// Directed bench for seq_rca_adder: three instances with DIGIT = 4, 1 and 16 on WIDTH = 16.
module tb_seq_rca_adder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] x = '0;
   logic [15:0] y = '0;
   logic        sub = 1'b0;
   logic        iv [3];
   logic        ir [3];
   logic        ovl [3];
   logic        ordy [3];
   logic [15:0] zz [3];
   logic [4:0]  fl [3];   // {sign, zero, carry, parity, overflow}

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int D = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
      logic s, zr, c, p, o;
      seq_rca_adder #(.WIDTH(16), .DIGIT(D)) u_dut (
         .clk(clk), .rst_n(rst_n), .in_valid(iv[g]), .in_ready(ir[g]),
         .x(x), .y(y), .sub(sub), .out_valid(ovl[g]), .out_ready(ordy[g]),
         .z(zz[g]), .sign(s), .zero(zr), .carry(c), .parity(p), .overflow(o));
      assign fl[g] = {s, zr, c, p, o};
   end

   // Drive one operation into instance d; lat = cycles from accept edge to out_valid, -1 on timeout.
   task automatic do_op(input int d, input logic [15:0] a, input logic [15:0] b,
                        input logic s, output int lat);
      @(negedge clk);
      x = a; y = b; sub = s; iv[d] = 1'b1;
      @(posedge clk);
      #1 iv[d] = 1'b0;
      lat = 0;
      while (!ovl[d] && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
      if (!ovl[d]) lat = -1;
   endtask

   task automatic release_result(input int d);
      @(negedge clk);
      ordy[d] = 1'b1;
      @(posedge clk);
      #1 ordy[d] = 1'b0;
   endtask

   task automatic test_reset;
      #3;
      for (int d = 0; d < 3; d++) begin
         n_chk++; if (ir[d] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready[%0d] got %b want 1", d, ir[d]); end
         n_chk++; if (ovl[d] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d] got %b want 0", d, ovl[d]); end
         n_chk++; if (zz[d] !== 16'h0000) begin n_fail++; $display("FAIL reset_z[%0d] got %h want 0000", d, zz[d]); end
         n_chk++; if (fl[d] !== 5'b00000) begin n_fail++; $display("FAIL reset_flags[%0d] got %b want 00000", d, fl[d]); end
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_add;
      int lat;
      do_op(0, 16'h1234, 16'h4321, 1'b0, lat);
      n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL add_latency got %0d want 4", lat); end
      n_chk++; if (zz[0] !== 16'h5555) begin n_fail++; $display("FAIL add_z got %h want 5555", zz[0]); end
      n_chk++; if (fl[0] !== 5'b00010) begin n_fail++; $display("FAIL add_flags got %b want 00010", fl[0]); end
      release_result(0);
   endtask

   task automatic test_wrap;
      int lat;
      do_op(0, 16'hFFFF, 16'h0001, 1'b0, lat);
      n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL wrap_latency got %0d want 4", lat); end
      n_chk++; if (zz[0] !== 16'h0000) begin n_fail++; $display("FAIL wrap_z got %h want 0000", zz[0]); end
      n_chk++; if (fl[0] !== 5'b01110) begin n_fail++; $display("FAIL wrap_flags got %b want 01110", fl[0]); end
      release_result(0);
   endtask

   task automatic test_overflow;
      int lat;
      logic [15:0] exp_z;
      logic [4:0]  exp_f;
`ifdef SEQ_RCA_ADDER_SAT_EN
      exp_z = 16'h7FFF; exp_f = 5'b00001;
`else
      exp_z = 16'h8000; exp_f = 5'b10001;
`endif
      do_op(0, 16'h7FFF, 16'h0001, 1'b0, lat);
      n_chk++; if (zz[0] !== exp_z) begin n_fail++; $display("FAIL ovf_z got %h want %h", zz[0], exp_z); end
      n_chk++; if (fl[0] !== exp_f) begin n_fail++; $display("FAIL ovf_flags got %b want %b", fl[0], exp_f); end
      release_result(0);
   endtask

   task automatic test_sub_digits;
      int lat;
      int exp_lat [3];
      exp_lat[0] = 4; exp_lat[1] = 16; exp_lat[2] = 1;
      for (int d = 0; d < 3; d++) begin
         do_op(d, 16'h0005, 16'h0007, 1'b1, lat);
         n_chk++; if (lat !== exp_lat[d]) begin n_fail++; $display("FAIL sub_latency[%0d] got %0d want %0d", d, lat, exp_lat[d]); end
         n_chk++; if (zz[d] !== 16'hFFFE) begin n_fail++; $display("FAIL sub_z[%0d] got %h want fffe", d, zz[d]); end
         n_chk++; if (fl[d] !== 5'b10000) begin n_fail++; $display("FAIL sub_flags[%0d] got %b want 10000", d, fl[d]); end
         release_result(d);
      end
   endtask

   task automatic test_back_to_back_hold;
      int lat;
      do_op(0, 16'h00F0, 16'h000F, 1'b0, lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         x = 16'hAAAA + 16'(i); y = 16'h1111; sub = 1'b0; iv[0] = 1'b1;
         @(posedge clk);
         #1;
         n_chk++; if (ovl[0] !== 1'b1) begin n_fail++; $display("FAIL hold_out_valid[%0d] got %b want 1", i, ovl[0]); end
         n_chk++; if (ir[0] !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d] got %b want 0", i, ir[0]); end
         n_chk++; if (zz[0] !== 16'h00FF) begin n_fail++; $display("FAIL hold_z[%0d] got %h want 00ff", i, zz[0]); end
         n_chk++; if (fl[0] !== 5'b00010) begin n_fail++; $display("FAIL hold_flags[%0d] got %b want 00010", i, fl[0]); end
      end
      iv[0] = 1'b0;
      release_result(0);
      n_chk++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b want 1", ir[0]); end
      n_chk++; if (ovl[0] !== 1'b0) begin n_fail++; $display("FAIL release_out_valid got %b want 0", ovl[0]); end
      repeat (6) @(posedge clk);
      #1;
      n_chk++; if (ovl[0] !== 1'b0) begin n_fail++; $display("FAIL not_queued_out_valid got %b want 0", ovl[0]); end
      n_chk++; if (zz[0] !== 16'h00FF) begin n_fail++; $display("FAIL idle_z_kept got %h want 00ff", zz[0]); end
   endtask

   task automatic test_reset_mid_run;
      int lat;
      @(negedge clk);
      x = 16'h1111; y = 16'h2222; sub = 1'b0; iv[0] = 1'b1;
      @(posedge clk);
      #1 iv[0] = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if (ovl[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b want 0", ovl[0]); end
      n_chk++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", ir[0]); end
      n_chk++; if (zz[0] !== 16'h0000) begin n_fail++; $display("FAIL midrst_z got %h want 0000", zz[0]); end
      n_chk++; if (fl[0] !== 5'b00000) begin n_fail++; $display("FAIL midrst_flags got %b want 00000", fl[0]); end
      @(negedge clk) rst_n = 1'b1;
      do_op(0, 16'h0100, 16'h00FF, 1'b0, lat);
      n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL post_rst_latency got %0d want 4", lat); end
      n_chk++; if (zz[0] !== 16'h01FF) begin n_fail++; $display("FAIL post_rst_z got %h want 01ff", zz[0]); end
      n_chk++; if (fl[0] !== 5'b00000) begin n_fail++; $display("FAIL post_rst_flags got %b want 00000", fl[0]); end
      release_result(0);
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         iv[d] = 1'b0;
         ordy[d] = 1'b0;
      end
      test_reset;
      test_add;
      test_wrap;
      test_overflow;
      test_sub_digits;
      test_back_to_back_hold;
      test_reset_mid_run;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
